// File: rtl/dino_jump_ctrl.sv
// -----------------------------------------------------------------------------
// dino_jump_ctrl
//
// Vertical motion controller for the dinosaur sprite. Converts a jump button
// press into a frame-synchronous ballistic trajectory with integer gravity,
// freezes the sprite on collision and returns it to the ground on restart.
// A built-in divider produces the per-frame motion tick.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   jump        raw jump button (asynchronous level, synchronized here)
//   isover      collision flag from the collision checker
//   restart     game restart (synchronous level)
//   dinosaur_y  current sprite y (screen y grows downward)
//   airborne    high while rising or falling
//   state       0=GROUND, 1=RISE, 2=FALL, 3=DEAD
//   frame_tick  one-cycle pulse per frame
// -----------------------------------------------------------------------------
module dino_jump_ctrl #(
   parameter int GROUND_Y = 475,
   parameter int Y_MIN    = 300,
   parameter int JUMP_V0  = 12,
   parameter int GRAVITY  = 1,
   parameter int TICK_DIV = 833333
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       jump,
   input  logic       isover,
   input  logic       restart,
   output logic [9:0] dinosaur_y,
   output logic       airborne,
   output logic [1:0] state,
   output logic       frame_tick
);

   localparam logic [1:0] S_GROUND = 2'd0;
   localparam logic [1:0] S_RISE   = 2'd1;
   localparam logic [1:0] S_FALL   = 2'd2;
   localparam logic [1:0] S_DEAD   = 2'd3;

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [9:0]         GROUND_Y_W = 10'(GROUND_Y);
   localparam logic [9:0]         Y_MIN_W    = 10'(Y_MIN);
   localparam logic signed [10:0] Y_MIN_S    = 11'(Y_MIN);
   localparam logic [10:0]        GROUND_S   = 11'(GROUND_Y);
   localparam logic [7:0]         V0_W       = 8'(JUMP_V0);
   localparam logic [7:0]         GRAV_W     = 8'(GRAVITY);

   logic [CNT_W-1:0] tick_cnt;
   logic             jump_p0, jump_p1, jump_p2;
   logic             jump_edge;
   logic             pending;
   logic [7:0]       vel;

   logic signed [10:0] rise_diff;
   logic [8:0]         vel_fall;
   logic [10:0]        fall_sum;

   // Ceiling clamp: the rising position may never go above Y_MIN on screen.
   function automatic logic [9:0] clamp_ceiling(input logic signed [10:0] diff);
      if (diff < Y_MIN_S)
         return Y_MIN_W;
      else
         return diff[9:0];
   endfunction

   assign airborne = (state == S_RISE) || (state == S_FALL);

   // Sums are widened to 11 bits so nothing wraps before the compare/clamp.
   assign rise_diff = $signed({1'b0, dinosaur_y}) - $signed({3'b000, vel});
   assign vel_fall  = {1'b0, vel} + {1'b0, GRAV_W};
   assign fall_sum  = {1'b0, dinosaur_y} + {2'b00, vel_fall};

   // ---- stage: frame tick divider (free-running, never cleared by restart)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt   <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= (tick_cnt == TICK_LAST);
         if (tick_cnt == TICK_LAST)
            tick_cnt <= '0;
         else
            tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // ---- stage: jump synchronizer and rising-edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         jump_p0 <= 1'b0;
         jump_p1 <= 1'b0;
         jump_p2 <= 1'b0;
      end else begin
         jump_p0 <= jump;
         jump_p1 <= jump_p0;
         jump_p2 <= jump_p1;
      end
   end

   // A held button gives a single edge, hence a single jump.
   assign jump_edge = jump_p1 & ~jump_p2;

   // ---- stage: motion state machine
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_GROUND;
         dinosaur_y <= GROUND_Y_W;
         vel        <= 8'd0;
         pending    <= 1'b0;
      end else if (restart) begin
         state      <= S_GROUND;
         dinosaur_y <= GROUND_Y_W;
         vel        <= 8'd0;
         pending    <= 1'b0;
      end else begin
         case (state)
            S_GROUND: begin
               if (isover) begin
                  state   <= S_DEAD;
                  pending <= 1'b0;
               end else if (frame_tick && pending) begin
                  // Take-off tick: only velocity is loaded, y moves next tick.
                  vel     <= V0_W;
                  pending <= 1'b0;
                  state   <= S_RISE;
               end else if (jump_edge) begin
                  // An edge coinciding with a tick waits for the following tick.
                  pending <= 1'b1;
               end
            end
            S_RISE: begin
               if (isover) begin
                  state   <= S_DEAD;
                  pending <= 1'b0;
               end else if (frame_tick) begin
                  dinosaur_y <= clamp_ceiling(rise_diff);
                  if (vel <= GRAV_W) begin
                     vel   <= 8'd0;
                     state <= S_FALL;
                  end else begin
                     vel <= vel - GRAV_W;
                  end
               end
            end
            S_FALL: begin
               if (isover) begin
                  state   <= S_DEAD;
                  pending <= 1'b0;
               end else if (frame_tick) begin
                  if (fall_sum >= GROUND_S) begin
                     dinosaur_y <= GROUND_Y_W;
                     vel        <= 8'd0;
                     state      <= S_GROUND;
                  end else begin
                     dinosaur_y <= fall_sum[9:0];
                     vel        <= vel_fall[7:0];
                  end
               end
            end
            default: begin
               // DEAD: everything frozen until restart.
               pending <= 1'b0;
            end
         endcase
      end
   end

endmodule
